// File: rtl/apb_reg_pkg.sv
// Shared definitions for the APB register completer: register offsets,
// FSM state encoding, access types and small decode/merge helpers.
package apb_reg_pkg;

  localparam logic [31:0] OFF_CTRL     = 32'h0000_0000;
  localparam logic [31:0] OFF_SCRATCH  = 32'h0000_0004;
  localparam logic [31:0] OFF_STATUS   = 32'h0000_0008;
  localparam logic [31:0] OFF_IRQ_PEND = 32'h0000_000C;
  localparam logic [31:0] OFF_IRQ_EN   = 32'h0000_0010;
  localparam logic [31:0] OFF_ID       = 32'h0000_0014;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } apb_state_t;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_RW   = 2'd1,
    ACC_RO   = 2'd2,
    ACC_W1C  = 2'd3
  } acc_type_t;

  // Access type of a byte address; anything not exactly on a register is unmapped.
  function automatic acc_type_t reg_access(input logic [31:0] addr);
    acc_type_t acc;
    case (addr)
      OFF_CTRL, OFF_SCRATCH, OFF_IRQ_EN: acc = ACC_RW;
      OFF_STATUS, OFF_ID:                acc = ACC_RO;
      OFF_IRQ_PEND:                      acc = ACC_W1C;
      default:                           acc = ACC_NONE;
    endcase
    return acc;
  endfunction

  // Replace the byte lanes of old_val selected by strb with the lanes of new_val.
  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: cleared by load, counts up while enabled and holds
// at the terminal count, which it flags on tc.
module apb_wait_ctr #(
  parameter int           W    = 4,
  parameter logic [W-1:0] TERM = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count;

  // Reload to zero outside the access phase, count up to the terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer with a small register file (CTRL, SCRATCH, STATUS,
// IRQ_PEND, IRQ_EN, ID), programmable wait states and a level interrupt.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transfer; a setup cycle (psel & !penable) starts one
// ST_ACCESS | access phase; wait counter runs, pready at terminal count
// ST_DONE   | cycle after completion; a new setup here is back-to-back
module apb_reg_completer
  import apb_reg_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA0B0_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [31:0]       status_i,
  input  logic [7:0]        irq_evt_i,
  output logic [31:0]       ctrl_o,
  output logic              irq_o
);

  apb_state_t        state, state_nxt;
  logic              setup;
  logic              tc;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       addr_ext;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  acc_type_t         acc;
  logic              err;
  logic              wr_commit;
  logic [31:0]       rd_mux;
  logic [31:0]       ctrl_q, scratch_q;
  logic [7:0]        pend_q, en_q, pend_clr;
  logic              irq_q;

  assign setup = psel && !penable;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; psel falling during the access phase abandons the transfer
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (setup) state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (!psel)   state_nxt = ST_IDLE;
        else if (tc) state_nxt = ST_DONE;
      end
      ST_DONE:   state_nxt = setup ? ST_ACCESS : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  apb_wait_ctr #(
    .W    (4),
    .TERM (4'(WAIT_STATES))
  ) u_wait_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (state != ST_ACCESS),
    .en   ((state == ST_ACCESS) && psel),
    .tc   (tc)
  );

  // Capture the request in its setup cycle; later bus changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if ((state != ST_ACCESS) && setup) begin
      addr_q  <= paddr;
      wr_q    <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
    end
  end

  assign addr_ext  = 32'(addr_q);
  assign acc       = reg_access(addr_ext);
  assign err       = (acc == ACC_NONE) || (addr_q[1:0] != 2'b00) || (wr_q && (acc == ACC_RO));
  assign pready    = (state == ST_ACCESS) && psel && tc;
  assign pslverr   = pready && err;
  assign wr_commit = pready && wr_q && !err;

  // Read data mux on the captured address
  always_comb begin
    rd_mux = '0;
    case (addr_ext)
      OFF_CTRL:     rd_mux = ctrl_q;
      OFF_SCRATCH:  rd_mux = scratch_q;
      OFF_STATUS:   rd_mux = status_i;
      OFF_IRQ_PEND: rd_mux = {24'h0, pend_q};
      OFF_IRQ_EN:   rd_mux = {24'h0, en_q};
      OFF_ID:       rd_mux = ID_VALUE;
      default:      rd_mux = '0;
    endcase
  end

  assign prdata = (pready && !wr_q && !err) ? rd_mux : '0;

  assign pend_clr = (wr_commit && (addr_ext == OFF_IRQ_PEND) && strb_q[0]) ? wdata_q[7:0] : 8'h00;

  // Register file; a new event wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      pend_q    <= '0;
      en_q      <= '0;
    end else begin
      if (wr_commit && (addr_ext == OFF_CTRL))
        ctrl_q <= merge_strb(ctrl_q, wdata_q, strb_q);
      if (wr_commit && (addr_ext == OFF_SCRATCH))
        scratch_q <= merge_strb(scratch_q, wdata_q, strb_q);
      if (wr_commit && (addr_ext == OFF_IRQ_EN) && strb_q[0])
        en_q <= wdata_q[7:0];
      pend_q <= (pend_q & ~pend_clr) | irq_evt_i;
    end
  end

  // Registered interrupt output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |(pend_q & en_q);
  end

  assign irq_o  = irq_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: directed steps plus a randomized phase
// against a behavioural register-map model. Three instances cover
// WAIT_STATES of 1 (main, modelled), 0 and 3.
module tb_apb_reg_completer;

  localparam logic [31:0] ID_VAL = 32'hA0B0_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sel;
  logic        penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] status_i;
  logic [7:0]  irq_evt;

  logic [31:0] prdata_a [3];
  logic        pready_a [3];
  logic        pslverr_a [3];
  logic [31:0] ctrl_a [3];
  logic        irq_a [3];

  int errors = 0;
  int checks = 0;
  int rdy_cnt [3] = '{0, 0, 0};

  logic [31:0] m_ctrl, m_scratch;
  logic [7:0]  m_pend, m_en;

  always #5 clk = ~clk;

  apb_reg_completer #(.ADDR_W(12), .WAIT_STATES(1), .ID_VALUE(ID_VAL)) u_dut (
    .clk(clk), .rst(rst), .psel(sel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[0]),
    .pready(pready_a[0]), .pslverr(pslverr_a[0]), .status_i(status_i),
    .irq_evt_i(irq_evt), .ctrl_o(ctrl_a[0]), .irq_o(irq_a[0]));

  apb_reg_completer #(.ADDR_W(12), .WAIT_STATES(0), .ID_VALUE(ID_VAL)) u_dut_ws0 (
    .clk(clk), .rst(rst), .psel(sel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[1]),
    .pready(pready_a[1]), .pslverr(pslverr_a[1]), .status_i(status_i),
    .irq_evt_i(irq_evt), .ctrl_o(ctrl_a[1]), .irq_o(irq_a[1]));

  apb_reg_completer #(.ADDR_W(12), .WAIT_STATES(3), .ID_VALUE(ID_VAL)) u_dut_ws3 (
    .clk(clk), .rst(rst), .psel(sel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[2]),
    .pready(pready_a[2]), .pslverr(pslverr_a[2]), .status_i(status_i),
    .irq_evt_i(irq_evt), .ctrl_o(ctrl_a[2]), .irq_o(irq_a[2]));

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (pready_a[d]) rdy_cnt[d]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic wr, input logic [11:0] a);
    logic mapped;
    mapped = (a == 12'h000) || (a == 12'h004) || (a == 12'h008) ||
             (a == 12'h00C) || (a == 12'h010) || (a == 12'h014);
    return !mapped || (wr && ((a == 12'h008) || (a == 12'h014)));
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h000: return m_ctrl;
      12'h004: return m_scratch;
      12'h008: return status_i;
      12'h00C: return {24'h0, m_pend};
      12'h010: return {24'h0, m_en};
      12'h014: return ID_VAL;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b] && a == 12'h000) m_ctrl[8*b +: 8] = d[8*b +: 8];
      if (s[b] && a == 12'h004) m_scratch[8*b +: 8] = d[8*b +: 8];
    end
    if (s[0] && a == 12'h00C) m_pend = m_pend & ~d[7:0];
    if (s[0] && a == 12'h010) m_en = d[7:0];
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_scratch = '0; m_pend = '0; m_en = '0;
  endtask

  // One APB transfer on instance d, entered and left at #1 after a rising edge.
  // keep leaves psel high so the next call forms a back-to-back setup.
  task automatic xfer(input int d, input logic wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input logic keep,
                      input logic [7:0] evt_at_commit,
                      output logic [31:0] rd, output logic err, output int cyc);
    logic got;
    sel = '0; sel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge clk); #1 penable = 1'b1;
    cyc = 0; rd = '0; err = 1'b0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (pready_a[d]) begin
        got = 1'b1; rd = prdata_a[d]; err = pslverr_a[d];
        irq_evt = evt_at_commit;
      end
    end
    check("pready_seen", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    irq_evt = 8'h00;
    if (!keep || !got) begin sel = '0; penable = 1'b0; end
  endtask

  task automatic m_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; logic err; int cyc; logic exp_err;
    exp_err = model_err(1'b1, a);
    xfer(0, 1'b1, a, d, s, 1'b0, 8'h00, rd, err, cyc);
    if (!exp_err) model_write(a, d, s);
    check("wr_err", {31'b0, err}, {31'b0, exp_err});
    check("wr_cycles", cyc, 32'd2);
    check("ctrl_o", ctrl_a[0], m_ctrl);
  endtask

  task automatic m_read(input logic [11:0] a, output logic [31:0] rd, output logic err);
    int cyc; logic [31:0] exp; logic exp_err;
    exp_err = model_err(1'b0, a);
    exp = exp_err ? 32'h0 : model_read(a);
    xfer(0, 1'b0, a, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, cyc);
    check("rd_data", rd, exp);
    check("rd_err", {31'b0, err}, {31'b0, exp_err});
    check("rd_cycles", cyc, 32'd2);
  endtask

  logic [11:0] addrs [10] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                              12'h014, 12'h018, 12'h002, 12'h011, 12'h100};

  initial begin
    logic [31:0] rd;
    logic        err;
    int          cyc;
    int          r0;
    logic [11:0] a;
    logic [7:0]  ev;

    sel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    status_i = 32'h0; irq_evt = 8'h00;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_prdata", prdata_a[d], 32'h0);
      check("rst_pready", {31'b0, pready_a[d]}, 32'h0);
      check("rst_pslverr", {31'b0, pslverr_a[d]}, 32'h0);
      check("rst_ctrl", ctrl_a[d], 32'h0);
      check("rst_irq", {31'b0, irq_a[d]}, 32'h0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // full-word write and read back
    m_write(12'h004, 32'hDEADBEEF, 4'hF);
    m_read(12'h004, rd, err);
    check("scratch_full", rd, 32'hDEADBEEF);
    check("scratch_full_err", {31'b0, err}, 32'h0);

    // single-lane write
    m_write(12'h004, 32'h12345678, 4'hF);
    m_write(12'h004, 32'h000000FF, 4'b0001);
    m_read(12'h004, rd, err);
    check("scratch_lane0", rd, 32'h123456FF);

    // error responses
    m_read(12'h018, rd, err);
    check("err_unmapped", {31'b0, err}, 32'd1);
    m_write(12'h014, 32'h5555_5555, 4'hF);
    m_read(12'h002, rd, err);
    check("err_misaligned", {31'b0, err}, 32'd1);
    m_write(12'h008, 32'hFFFF_FFFF, 4'hF);
    m_read(12'h014, rd, err);
    check("id_value", rd, ID_VAL);
    m_write(12'h000, 32'hCAFE_0001, 4'hF);
    check("ctrl_written", ctrl_a[0], 32'hCAFE_0001);

    // interrupt: enable, pulse, W1C colliding with a new pulse, plain W1C
    m_write(12'h010, 32'h0000_0001, 4'h1);
    irq_evt = 8'h01; m_pend = m_pend | 8'h01;
    @(posedge clk); #1 irq_evt = 8'h00;
    check("irq_lag", {31'b0, irq_a[0]}, 32'd0);
    @(posedge clk); #1;
    check("irq_set", {31'b0, irq_a[0]}, 32'd1);
    xfer(0, 1'b1, 12'h00C, 32'h0000_0001, 4'h1, 1'b0, 8'h01, rd, err, cyc);
    m_pend = (m_pend & ~8'h01) | 8'h01;
    check("w1c_collide_err", {31'b0, err}, 32'd0);
    m_read(12'h00C, rd, err);
    check("pend_set_wins", rd, 32'h0000_0001);
    check("irq_still_set", {31'b0, irq_a[0]}, 32'd1);
    m_write(12'h00C, 32'h0000_0001, 4'h1);
    check("irq_before_clear", {31'b0, irq_a[0]}, 32'd1);
    @(posedge clk); #1;
    check("irq_cleared", {31'b0, irq_a[0]}, 32'd0);

    // abort: psel dropped in the first access cycle of a CTRL write
    sel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge clk); #1 sel = 3'b000; penable = 1'b1;
    @(negedge clk);
    check("abort_no_ready", {31'b0, pready_a[0]}, 32'd0);
    @(posedge clk); #1;
    // penable without a setup cycle is ignored
    r0 = rdy_cnt[0];
    sel = 3'b001; penable = 1'b1;
    repeat (4) @(posedge clk);
    #1 sel = 3'b000; penable = 1'b0;
    check("no_setup_ignored", rdy_cnt[0] - r0, 32'd0);
    check("abort_ctrl", ctrl_a[0], 32'hCAFE_0001);
    m_read(12'h000, rd, err);

    // reset while a read is returning data
    m_write(12'h004, 32'h5555_AAAA, 4'hF);
    sel = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("midrst_prdata", prdata_a[0], 32'h0);
    check("midrst_pready", {31'b0, pready_a[0]}, 32'h0);
    check("midrst_pslverr", {31'b0, pslverr_a[0]}, 32'h0);
    check("midrst_ctrl", ctrl_a[0], 32'h0);
    check("midrst_irq", {31'b0, irq_a[0]}, 32'h0);
    sel = 3'b000; penable = 1'b0;
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    m_read(12'h004, rd, err);
    check("post_rst_scratch", rd, 32'h0);
    m_write(12'h004, 32'h0BAD_F00D, 4'hF);
    m_read(12'h004, rd, err);
    check("post_rst_xfer", rd, 32'h0BAD_F00D);

    // back-to-back on WAIT_STATES=0 and WAIT_STATES=3
    for (int d = 1; d < 3; d++) begin
      int exp_cyc;
      exp_cyc = (d == 1) ? 1 : 4;
      r0 = rdy_cnt[d];
      xfer(d, 1'b1, 12'h004, 32'h1111_2222 + d, 4'hF, 1'b1, 8'h00, rd, err, cyc);
      check("b2b_wr_cycles", cyc, exp_cyc);
      xfer(d, 1'b0, 12'h004, 32'h0, 4'h0, 1'b1, 8'h00, rd, err, cyc);
      check("b2b_rd_cycles", cyc, exp_cyc);
      check("b2b_rd_data", rd, 32'h1111_2222 + d);
      xfer(d, 1'b0, 12'h014, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, cyc);
      check("b2b_id_cycles", cyc, exp_cyc);
      check("b2b_id_data", rd, ID_VAL);
      @(negedge clk);
      check("b2b_ready_count", rdy_cnt[d] - r0, 32'd3);
      @(posedge clk); #1;
    end

    // randomized traffic on the main instance against the model
    m_write(12'h010, 32'h0000_00FF, 4'h1);
    for (int n = 0; n < 40; n++) begin
      ev = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) begin
        irq_evt = ev; m_pend = m_pend | ev;
        @(posedge clk); #1 irq_evt = 8'h00;
      end
      a = addrs[$urandom_range(0, 9)];
      status_i = $urandom;
      if ($urandom_range(0, 1) == 1) m_write(a, $urandom, 4'($urandom_range(0, 15)));
      else                           m_read(a, rd, err);
      @(posedge clk); #1;
      check("rand_irq", {31'b0, irq_a[0]}, {31'b0, |(m_pend & m_en)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_reg_completer.md
APB_REG_COMPLETER -- requirements
Module: apb_reg_completer

Interface
REQ-001 Parameter ADDR_W, default 12, is the APB address width.
REQ-002 Parameter WAIT_STATES, default 1, range 0..15, is the number of extra access cycles before PREADY.
REQ-003 Parameter ID_VALUE, default 32'hA0B0_0001, is the read-only ID register value.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 psel  in  1  APB select.
REQ-007 penable  in  1  APB access phase.
REQ-008 pwrite  in  1  1 = write.
REQ-009 paddr  in  ADDR_W  byte address.
REQ-010 pwdata  in  32  write data.
REQ-011 pstrb  in  4  byte write strobes.
REQ-012 prdata  out  32  read data.
REQ-013 pready  out  1  transfer complete.
REQ-014 pslverr  out  1  transfer error.
REQ-015 status_i  in  32  live status, sampled on read.
REQ-016 irq_evt_i  in  8  one-cycle event pulses.
REQ-017 ctrl_o  out  32  CTRL register contents.
REQ-018 irq_o  out  1  level interrupt.

Function
REQ-019 The register map SHALL be: 0x00 CTRL RW; 0x04 SCRATCH RW; 0x08 STATUS RO (status_i); 0x0C IRQ_PEND W1C, bits 7:0; 0x10 IRQ_EN RW, bits 7:0; 0x14 ID RO.
REQ-020 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-021 IDLE -> ACCESS when psel=1 and penable=0; paddr, pwrite, pwdata and pstrb are captured in that setup cycle.
REQ-022 In ACCESS the wait counter SHALL count up from 0, and pready SHALL be 1 in the access cycle where count==WAIT_STATES (the first access cycle when WAIT_STATES=0); the state then moves to DONE.
REQ-023 DONE -> ACCESS when psel=1 and penable=0 (back-to-back transfer); otherwise DONE -> IDLE.
REQ-024 If psel drops while in ACCESS before pready, the transfer SHALL abort to IDLE with no register update.
REQ-025 penable=1 without a preceding setup cycle SHALL be ignored.
REQ-026 Writes SHALL commit on the pready cycle, per byte lane enabled by pstrb.
REQ-027 prdata SHALL be valid only when pready=1 and SHALL be 0 otherwise.
REQ-028 pslverr SHALL be 1 only with pready, for: an unmapped address, paddr[1:0]!=0, or a write to STATUS or ID; erroring writes have no effect.
REQ-029 IRQ_PEND[i] SHALL set on irq_evt_i[i] and clear on a W1C of 1 with pstrb[0]=1; if set and clear occur in the same cycle, set wins.
REQ-030 irq_o SHALL be registered: irq_o = OR(IRQ_PEND & IRQ_EN), one cycle after the change.
REQ-031 ctrl_o SHALL update the cycle after the write commit.

Reset
REQ-032 On rst, the FSM SHALL go to IDLE and CTRL, SCRATCH, IRQ_PEND, IRQ_EN, pready, pslverr, prdata, irq_o and the wait counter SHALL all be 0.
REQ-033 rst asserted mid-transfer SHALL abort the transfer with no write; the first transfer after release is accepted normally.

Structure
REQ-034 A shared package apb_reg_pkg SHALL hold the register offset constants, the FSM state enum and the W1C/RO access-type enum.
REQ-035 A single sub-module apb_wait_ctr (a load/count/terminal-count counter) SHALL implement the wait-state timing.

Verification
REQ-036 Write 0xDEADBEEF to 0x04 with pstrb=4'hF, then read 0x04 -> read returns 0xDEADBEEF, pslverr=0, pready on access cycle 2 (WAIT_STATES=1).
REQ-037 Write 0x0000_00FF to 0x04 with pstrb=4'b0001 over an existing 0x12345678 -> SCRATCH reads 0x123456FF.
REQ-038 Read 0x18, write 0x14, access 0x02 -> pslverr=1 with pready each time; ID still reads ID_VALUE.
REQ-039 Set IRQ_EN=0x01, pulse irq_evt_i[0] -> irq_o=1; W1C 0x01 in the same cycle as a new pulse -> PEND[0] stays 1; W1C alone -> irq_o=0 one cycle later.
REQ-040 Drop psel in the first access cycle of a write to CTRL -> CTRL unchanged and FSM back in IDLE; assert rst mid-read -> all outputs 0.
REQ-041 Back-to-back transfers with WAIT_STATES=0 and 3 -> pready exactly once per transfer, at access cycle 1 and 4 respectively.
